// File: rtl/host_bus_master.sv
// Host-side bus master: drains a command FIFO onto a 054539-style NCS/NRD/NWR register bus
// with programmable setup, strobe and hold timing, WAIT extension and timeout abort.
module host_bus_master #(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned T_SU       = 1,
    parameter int unsigned T_CS       = 2,
    parameter int unsigned T_STB      = 15,
    parameter int unsigned T_HD       = 1,
    parameter int unsigned T_REC      = 1,
    parameter int unsigned WAIT_MAX   = 255
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic          CMD_WR,
    input  logic [AW-1:0] CMD_ADDR,
    input  logic [DW-1:0] CMD_DATA,
    output logic          RSP_VALID,
    output logic [DW-1:0] RSP_DATA,
    output logic          RSP_ERR,
    output logic          ERR_TIMEOUT,
    output logic          BUSY,
    output logic [AW-1:0] BUS_AB,
    output logic [DW-1:0] BUS_DB_OUT,
    output logic          BUS_DB_OE,
    input  logic [DW-1:0] BUS_DB_IN,
    output logic          BUS_NCS,
    output logic          BUS_NRD,
    output logic          BUS_NWR,
    input  logic          BUS_WAIT
);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned FW   = 1 + AW + DW;
    localparam int unsigned TM1  = (T_SU > T_CS) ? T_SU : T_CS;
    localparam int unsigned TM2  = (TM1 > T_STB) ? TM1 : T_STB;
    localparam int unsigned TM3  = (TM2 > T_HD) ? TM2 : T_HD;
    localparam int unsigned TMAX = (TM3 > T_REC) ? TM3 : T_REC;
    localparam int unsigned CW   = $clog2(TMAX + 1);
    localparam int unsigned EW   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StSetup, StCsLead, StStrobe, StHold, StRecover
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [EW-1:0] ext;
    logic          is_wr;

    logic [FW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;
    logic          head_wr;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign CMD_READY = !full && !RES;
    assign push      = CMD_VALID && CMD_READY;
    assign pop       = (state == StIdle) && !empty;
    assign BUSY      = !empty || (state != StIdle);
    assign {head_wr, head_addr, head_data} = fifo_mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= {CMD_WR, CMD_ADDR, CMD_DATA};
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state       <= StIdle;
            cnt         <= '0;
            ext         <= '0;
            is_wr       <= 1'b0;
            BUS_AB      <= '0;
            BUS_DB_OUT  <= '0;
            BUS_DB_OE   <= 1'b0;
            BUS_NCS     <= 1'b1;
            BUS_NRD     <= 1'b1;
            BUS_NWR     <= 1'b1;
            RSP_VALID   <= 1'b0;
            RSP_ERR     <= 1'b0;
            RSP_DATA    <= '0;
            ERR_TIMEOUT <= 1'b0;
        end else begin
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            case (state)
                StIdle: begin
                    if (!empty) begin
                        BUS_AB     <= head_addr;
                        BUS_DB_OUT <= head_data;
                        BUS_DB_OE  <= head_wr;
                        is_wr      <= head_wr;
                        cnt        <= CW'(T_SU - 1);
                        state      <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt == '0) begin
                        BUS_NCS <= 1'b0;
                        cnt     <= CW'(T_CS - 1);
                        state   <= StCsLead;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StCsLead: begin
                    if (cnt == '0) begin
                        BUS_NWR <= !is_wr;
                        BUS_NRD <= is_wr;
                        ext     <= '0;
                        cnt     <= CW'(T_STB - 1);
                        state   <= StStrobe;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StStrobe: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (BUS_WAIT && ext != EW'(WAIT_MAX)) begin
                        ext <= ext + 1'b1;
                    end else begin
                        // WAIT still high here means the extension budget is spent: abort.
                        BUS_NWR <= 1'b1;
                        BUS_NRD <= 1'b1;
                        cnt     <= CW'(T_HD - 1);
                        state   <= StHold;
                        if (BUS_WAIT) ERR_TIMEOUT <= 1'b1;
                        if (!is_wr) begin
                            RSP_VALID <= 1'b1;
                            RSP_ERR   <= BUS_WAIT;
                            RSP_DATA  <= BUS_WAIT ? '1 : BUS_DB_IN;
                        end
                    end
                end
                StHold: begin
                    if (cnt == '0) begin
                        BUS_NCS   <= 1'b1;
                        BUS_DB_OE <= 1'b0;
                        cnt       <= CW'(T_REC - 1);
                        state     <= StRecover;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StRecover: begin
                    if (cnt == '0) state <= StIdle;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_host_bus_master.sv
// Bench for host_bus_master: a negedge bus monitor turns pin activity into transfer records
// which each scenario task compares against timings derived from the transfer rules.
module tb_host_bus_master;
    localparam int AW         = 10;
    localparam int DW         = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int T_SU       = 1;
    localparam int T_CS       = 2;
    localparam int T_STB      = 15;
    localparam int T_HD       = 1;
    localparam int T_REC      = 1;
    localparam int WAIT_MAX   = 4;
    localparam int PERIOD     = T_SU + T_CS + T_STB + T_HD + T_REC + 1;

    logic          CLK = 1'b0;
    logic          RES;
    logic          CMD_VALID, CMD_WR;
    logic [AW-1:0] CMD_ADDR;
    logic [DW-1:0] CMD_DATA;
    logic          CMD_READY, RSP_VALID, RSP_ERR, ERR_TIMEOUT, BUSY;
    logic [DW-1:0] RSP_DATA;
    logic [AW-1:0] BUS_AB;
    logic [DW-1:0] BUS_DB_OUT;
    logic          BUS_DB_OE;
    logic [DW-1:0] BUS_DB_IN = '0;
    logic          BUS_NCS, BUS_NRD, BUS_NWR;
    logic          BUS_WAIT = 1'b0;

    always #5 CLK = ~CLK;

    host_bus_master #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .T_SU(T_SU), .T_CS(T_CS),
        .T_STB(T_STB), .T_HD(T_HD), .T_REC(T_REC), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .CLK(CLK), .RES(RES), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_WR(CMD_WR), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .ERR_TIMEOUT(ERR_TIMEOUT), .BUSY(BUSY), .BUS_AB(BUS_AB), .BUS_DB_OUT(BUS_DB_OUT),
        .BUS_DB_OE(BUS_DB_OE), .BUS_DB_IN(BUS_DB_IN), .BUS_NCS(BUS_NCS),
        .BUS_NRD(BUS_NRD), .BUS_NWR(BUS_NWR), .BUS_WAIT(BUS_WAIT)
    );

    typedef struct {
        logic          wr;
        logic          both;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            lead;
        int            stb;
        int            hold;
        int            cs_len;
        int            oe_cnt;
        int            fall_cyc;
        int            rise_cyc;
    } rec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    rec_t          mon_q[$];
    rsp_t          rsp_q[$];
    int            wait_q[$];
    logic [DW-1:0] din_q[$];

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor plus target model: WAIT is held high for w cycles starting at the last counted
    // strobe cycle, and DB_IN carries the value queued for this transfer.
    initial begin : monitor
        rec_t cur;
        rsp_t rs;
        int   stb_k;
        int   cur_w;
        cur   = '{default: 0};
        stb_k = 0;
        cur_w = 0;
        forever begin
            @(negedge CLK);
            if (RES === 1'b1) begin
                cur      = '{default: 0};
                stb_k    = 0;
                cur_w    = 0;
                BUS_WAIT = 1'b0;
            end else begin
                if (RSP_VALID === 1'b1) begin
                    rs.data = RSP_DATA;
                    rs.err  = RSP_ERR;
                    rsp_q.push_back(rs);
                end
                if (BUS_NCS === 1'b0) begin
                    if (cur.cs_len == 0) cur.fall_cyc = cyc;
                    cur.cs_len++;
                    if (BUS_DB_OE === 1'b1) cur.oe_cnt++;
                    if (BUS_NWR === 1'b0 || BUS_NRD === 1'b0) begin
                        if (stb_k == 0) begin
                            cur_w = 0;
                            if (wait_q.size() > 0) cur_w = wait_q.pop_front();
                            if (din_q.size() > 0) BUS_DB_IN = din_q.pop_front();
                        end
                        stb_k++;
                        cur.stb++;
                        if (BUS_NWR === 1'b0) cur.wr = 1'b1;
                        if (BUS_NWR === 1'b0 && BUS_NRD === 1'b0) cur.both = 1'b1;
                        BUS_WAIT = (stb_k >= T_STB) && (stb_k < T_STB + cur_w);
                    end else begin
                        BUS_WAIT = 1'b0;
                        if (cur.stb == 0) cur.lead++;
                        else              cur.hold++;
                    end
                end else if (cur.cs_len != 0) begin
                    cur.addr     = BUS_AB;
                    cur.data     = BUS_DB_OUT;
                    cur.rise_cyc = cyc;
                    mon_q.push_back(cur);
                    cur      = '{default: 0};
                    stb_k    = 0;
                    BUS_WAIT = 1'b0;
                end
            end
        end
    end

    function automatic rec_t take_rec();
        rec_t r = '{default: 0};
        if (mon_q.size() > 0) r = mon_q.pop_front();
        return r;
    endfunction

    function automatic rsp_t take_rsp();
        rsp_t r = '{data: '0, err: 1'b0};
        if (rsp_q.size() > 0) r = rsp_q.pop_front();
        return r;
    endfunction

    function automatic int exp_stb(input int w);
        return T_STB + ((w > WAIT_MAX) ? WAIT_MAX : w);
    endfunction

    task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int w, input logic [DW-1:0] din, output int acc);
        int n = 0;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_WR    = wr;
        CMD_ADDR  = a;
        CMD_DATA  = d;
        while (CMD_READY !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        if (CMD_READY !== 1'b1) begin
            fails++;
            $display("FAIL push_accept: CMD_READY=%b after %0d cycles, required 1", CMD_READY, n);
        end
        wait_q.push_back(w);
        din_q.push_back(din);
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int n, input int budget, output int done);
        int k = 0;
        while ((BUSY !== 1'b0 || mon_q.size() < n) && k < budget) begin
            @(negedge CLK);
            k++;
        end
        done = cyc;
        tests++;
        if (BUSY !== 1'b0 || mon_q.size() < n) begin
            fails++;
            $display("FAIL wait_done: BUSY=%b records=%0d, required BUSY=0 records=%0d",
                     BUSY, mon_q.size(), n);
        end
    endtask

    task automatic test_reset();
        CMD_VALID = 1'b0;
        CMD_WR    = 1'b0;
        CMD_ADDR  = '0;
        CMD_DATA  = '0;
        RES       = 1'b1;
        repeat (3) @(negedge CLK);
        tests++;
        if ({BUS_NCS, BUS_NRD, BUS_NWR, BUS_DB_OE, BUSY, CMD_READY} !== 6'b111000) begin
            fails++;
            $display("FAIL reset_ctrl: ncs/nrd/nwr/oe/busy/ready=%b required 111000",
                     {BUS_NCS, BUS_NRD, BUS_NWR, BUS_DB_OE, BUSY, CMD_READY});
        end
        tests++;
        if ({RSP_VALID, RSP_ERR, ERR_TIMEOUT, BUS_AB, BUS_DB_OUT, RSP_DATA} !== '0) begin
            fails++;
            $display("FAIL reset_data: rsp=%b%b err=%b ab=%h db=%h rd=%h required all 0",
                     RSP_VALID, RSP_ERR, ERR_TIMEOUT, BUS_AB, BUS_DB_OUT, RSP_DATA);
        end
        RES = 1'b0;
        #1;
        tests++;
        if (CMD_READY !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: CMD_READY=%b required 1", CMD_READY);
        end
    endtask

    task automatic test_single_write();
        int   acc, done;
        rec_t r;
        push_cmd(1'b1, 10'h050, 8'h11, 0, 8'h00, acc);
        tests++;
        if (BUS_AB !== 10'h000) begin
            fails++;
            $display("FAIL wr_ab_early: AB=%h at accept edge, required 000", BUS_AB);
        end
        @(posedge CLK);
        #1;
        tests++;
        if ({BUS_AB, BUS_DB_OUT, BUS_DB_OE, BUS_NCS} !== {10'h050, 8'h11, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL wr_addr_phase: AB=%h DB=%h OE=%b NCS=%b required 050 11 1 1",
                     BUS_AB, BUS_DB_OUT, BUS_DB_OE, BUS_NCS);
        end
        @(posedge CLK);
        #1;
        tests++;
        if ({BUS_NCS, BUS_NWR} !== 2'b01) begin
            fails++;
            $display("FAIL wr_cs_phase: NCS=%b NWR=%b required 0 1", BUS_NCS, BUS_NWR);
        end
        wait_done(1, 100, done);
        r = take_rec();
        tests++;
        if ({r.wr, r.both, r.addr, r.data} !== {1'b1, 1'b0, 10'h050, 8'h11}) begin
            fails++;
            $display("FAIL wr_record: wr=%b both=%b addr=%h data=%h required 1 0 050 11",
                     r.wr, r.both, r.addr, r.data);
        end
        tests++;
        if (r.lead != T_CS || r.stb != T_STB || r.hold != T_HD) begin
            fails++;
            $display("FAIL wr_timing: lead=%0d stb=%0d hold=%0d required %0d %0d %0d",
                     r.lead, r.stb, r.hold, T_CS, T_STB, T_HD);
        end
        tests++;
        if (r.fall_cyc - acc != 1 + T_SU) begin
            fails++;
            $display("FAIL wr_latency: accept->NCS=%0d cycles required %0d",
                     r.fall_cyc - acc, 1 + T_SU);
        end
        tests++;
        if (r.oe_cnt != r.cs_len || rsp_q.size() != 0) begin
            fails++;
            $display("FAIL wr_oe_rsp: oe_cycles=%0d of %0d, rsp=%0d required all, 0",
                     r.oe_cnt, r.cs_len, rsp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs[5] = '{10'h051, 10'h21B, 10'h21C, 10'h222, 10'h223};
        logic [DW-1:0] datas[5] = '{8'h22, 8'h10, 8'h15, 8'h06, 8'h13};
        int            acc[5];
        int            done, prev_fall, last_rise, queued;
        rec_t          r;
        for (int i = 0; i < 5; i++) begin
            push_cmd(1'b1, addrs[i], datas[i], 0, 8'h00, acc[i]);
            // The first command is popped on the cycle after it lands; the rest stay queued.
            queued = (i == 0) ? 1 : i;
            tests++;
            if (CMD_READY !== logic'(queued < FIFO_DEPTH) || acc[i] - acc[0] != i) begin
                fails++;
                $display("FAIL b2b_ready[%0d]: ready=%b gap=%0d required %b %0d",
                         i, CMD_READY, acc[i] - acc[0], queued < FIFO_DEPTH, i);
            end
        end
        wait_done(5, 400, done);
        prev_fall = 0;
        last_rise = 0;
        for (int i = 0; i < 5; i++) begin
            r = take_rec();
            tests++;
            if ({r.wr, r.addr, r.data} !== {1'b1, addrs[i], datas[i]} || r.stb != T_STB ||
                (i > 0 && r.fall_cyc - prev_fall != PERIOD)) begin
                fails++;
                $display("FAIL b2b_xfer[%0d]: wr=%b addr=%h data=%h stb=%0d gap=%0d required 1 %h %h %0d %0d",
                         i, r.wr, r.addr, r.data, r.stb, r.fall_cyc - prev_fall,
                         addrs[i], datas[i], T_STB, PERIOD);
            end
            prev_fall = r.fall_cyc;
            last_rise = r.rise_cyc;
        end
        tests++;
        if (done != last_rise + T_REC) begin
            fails++;
            $display("FAIL b2b_busy_fall: BUSY fell at %0d required %0d", done, last_rise + T_REC);
        end
    endtask

    task automatic test_read();
        int   acc, done;
        rec_t r;
        rsp_t s;
        push_cmd(1'b0, 10'h223, 8'h5C, 0, 8'hA5, acc);
        wait_done(1, 100, done);
        r = take_rec();
        tests++;
        if (r.wr !== 1'b0 || r.stb != T_STB || r.oe_cnt != 0 || r.addr !== 10'h223) begin
            fails++;
            $display("FAIL rd_strobe: wr=%b stb=%0d oe=%0d addr=%h required 0 %0d 0 223",
                     r.wr, r.stb, r.oe_cnt, r.addr, T_STB);
        end
        tests++;
        if (rsp_q.size() != 1) begin
            fails++;
            $display("FAIL rd_rsp_count: %0d pulses required 1", rsp_q.size());
        end
        s = take_rsp();
        tests++;
        if ({s.data, s.err} !== {8'hA5, 1'b0}) begin
            fails++;
            $display("FAIL rd_rsp_data: data=%h err=%b required a5 0", s.data, s.err);
        end
    endtask

    task automatic test_wait_write();
        int   acc, done;
        rec_t r;
        push_cmd(1'b1, 10'h111, 8'hC3, 3, 8'h00, acc);
        wait_done(1, 100, done);
        r = take_rec();
        tests++;
        if (r.wr !== 1'b1 || r.stb != exp_stb(3) || ERR_TIMEOUT !== 1'b0 || rsp_q.size() != 0) begin
            fails++;
            $display("FAIL wait_write: wr=%b stb=%0d to=%b rsp=%0d required 1 %0d 0 0",
                     r.wr, r.stb, ERR_TIMEOUT, rsp_q.size(), exp_stb(3));
        end
    endtask

    task automatic test_timeout();
        int   acc, done;
        rec_t r;
        rsp_t s;
        push_cmd(1'b0, 10'h1AA, 8'h00, 1000, 8'h3C, acc);
        push_cmd(1'b1, 10'h155, 8'h5A, 0, 8'h00, acc);
        wait_done(2, 200, done);
        r = take_rec();
        tests++;
        if (r.wr !== 1'b0 || r.stb != T_STB + WAIT_MAX) begin
            fails++;
            $display("FAIL to_strobe: wr=%b stb=%0d required 0 %0d", r.wr, r.stb, T_STB + WAIT_MAX);
        end
        s = take_rsp();
        tests++;
        if ({s.data, s.err, ERR_TIMEOUT} !== {8'hFF, 1'b1, 1'b1} || rsp_q.size() != 0) begin
            fails++;
            $display("FAIL to_rsp: data=%h err=%b sticky=%b extra=%0d required ff 1 1 0",
                     s.data, s.err, ERR_TIMEOUT, rsp_q.size());
        end
        r = take_rec();
        tests++;
        if ({r.wr, r.addr, r.data} !== {1'b1, 10'h155, 8'h5A} || r.stb != T_STB) begin
            fails++;
            $display("FAIL to_next: wr=%b addr=%h data=%h stb=%0d required 1 155 5a %0d",
                     r.wr, r.addr, r.data, r.stb, T_STB);
        end
    endtask

    task automatic test_random();
        int            wopts[7] = '{0, 0, 1, 2, 3, 4, 6};
        int            acc, done, w, exp_cnt;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d, din, exp_data;
        rec_t          r;
        rsp_t          s;
        for (int i = 0; i < 10; i++) begin
            wr  = logic'($urandom_range(0, 1));
            a   = AW'($urandom);
            d   = DW'($urandom);
            din = DW'($urandom);
            w   = wopts[$urandom_range(0, 6)];
            push_cmd(wr, a, d, w, din, acc);
            wait_done(1, 100, done);
            r = take_rec();
            tests++;
            if (r.wr !== wr || r.addr !== a || (wr && r.data !== d) || r.stb != exp_stb(w) ||
                r.lead != T_CS || r.hold != T_HD || r.oe_cnt != (wr ? r.cs_len : 0)) begin
                fails++;
                $display("FAIL rand_xfer[%0d]: wr=%b addr=%h data=%h stb=%0d lead=%0d hold=%0d oe=%0d required %b %h %h %0d",
                         i, r.wr, r.addr, r.data, r.stb, r.lead, r.hold, r.oe_cnt,
                         wr, a, d, exp_stb(w));
            end
            exp_cnt  = wr ? 0 : 1;
            exp_data = (w > WAIT_MAX) ? '1 : din;
            tests++;
            if (rsp_q.size() != exp_cnt) begin
                fails++;
                $display("FAIL rand_rsp_count[%0d]: %0d required %0d", i, rsp_q.size(), exp_cnt);
            end
            if (!wr) begin
                s = take_rsp();
                tests++;
                if ({s.data, s.err} !== {exp_data, logic'(w > WAIT_MAX)}) begin
                    fails++;
                    $display("FAIL rand_rsp[%0d]: data=%h err=%b required %h %b",
                             i, s.data, s.err, exp_data, w > WAIT_MAX);
                end
            end
            rsp_q.delete();
        end
        tests++;
        if (ERR_TIMEOUT !== 1'b1) begin
            fails++;
            $display("FAIL sticky_timeout: ERR_TIMEOUT=%b required 1", ERR_TIMEOUT);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int k = 0;
        push_cmd(1'b1, 10'h0AB, 8'h77, 0, 8'h00, acc);
        push_cmd(1'b1, 10'h0AC, 8'h78, 0, 8'h00, acc);
        push_cmd(1'b0, 10'h0AD, 8'h00, 0, 8'h00, acc);
        while (BUS_NWR !== 1'b0 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        tests++;
        if (BUS_NWR !== 1'b0) begin
            fails++;
            $display("FAIL mid_strobe_start: NWR=%b after %0d cycles required 0", BUS_NWR, k);
        end
        repeat (4) @(posedge CLK);
        #2;
        RES = 1'b1;
        #1;
        tests++;
        if ({BUS_NWR, BUS_NRD, BUS_NCS, BUS_DB_OE, BUSY, CMD_READY} !== 6'b111000) begin
            fails++;
            $display("FAIL mid_reset_async: nwr/nrd/ncs/oe/busy/ready=%b required 111000",
                     {BUS_NWR, BUS_NRD, BUS_NCS, BUS_DB_OE, BUSY, CMD_READY});
        end
        wait_q.delete();
        din_q.delete();
        repeat (2) @(negedge CLK);
        RES = 1'b0;
        repeat (30) @(negedge CLK);
        tests++;
        if (mon_q.size() != 0 || rsp_q.size() != 0 || BUSY !== 1'b0 || BUS_NCS !== 1'b1 ||
            ERR_TIMEOUT !== 1'b0 || BUS_AB !== 10'h000) begin
            fails++;
            $display("FAIL mid_flush: xfers=%0d rsp=%0d busy=%b ncs=%b to=%b ab=%h required 0 0 0 1 0 000",
                     mon_q.size(), rsp_q.size(), BUSY, BUS_NCS, ERR_TIMEOUT, BUS_AB);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read();
        test_wait_write();
        test_timeout();
        test_random();
        test_reset_mid();
        test_single_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
